multicycle_ctrl: RTL

- Control FSM that sequences the multi-cycle RV32I core through the stages fetch, decode, execute, memory and writeback.
- Consumes the opcode and funct3 fields that the instruction decoder extracts from the latched instruction register (IR), plus a branch-compare result.
- Drives the datapath mux selects, register and PC write enables, and the instruction/data memory handshakes.
- Maintains a retired-instruction counter and a sticky trap state.

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_ctrl_classify.sv | 65 ++++++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcode constants, state/select enums and ALU select table for the RV32I controller
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } ctrl_state_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
    typedef enum logic [1:0] {ALU_A_RS1, ALU_A_PC, ALU_A_ZERO} alu_a_sel_t;
    typedef enum logic [1:0] {ALU_B_RS2, ALU_B_IMM} alu_b_sel_t;
    typedef enum logic [1:0] {PC_PC4, PC_TARGET} pc_sel_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    typedef enum logic [3:0] {
        CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_OP, CLS_OP_IMM,
        CLS_LUI, CLS_AUIPC, CLS_FENCE, CLS_SYSTEM, CLS_ILLEGAL
    } instr_class_t;

    typedef enum logic [1:0] {
        TRAP_ILLEGAL_OPC, TRAP_ILLEGAL_F3, TRAP_SYSTEM
    } trap_cause_t;

    typedef struct packed {
        imm_sel_t   imm;
        alu_a_sel_t a;
        alu_b_sel_t b;
    } alu_cfg_t;

    // Branches use the ALU for PC+imm; the comparator works in parallel.
    function automatic alu_cfg_t alu_cfg(input instr_class_t cls);
        alu_cfg_t cfg;
        cfg = '{imm: IMM_I, a: ALU_A_RS1, b: ALU_B_RS2};
        case (cls)
            CLS_OP_IMM, CLS_LOAD, CLS_JALR: cfg = '{imm: IMM_I, a: ALU_A_RS1,  b: ALU_B_IMM};
            CLS_STORE:                      cfg = '{imm: IMM_S, a: ALU_A_RS1,  b: ALU_B_IMM};
            CLS_BRANCH:                     cfg = '{imm: IMM_B, a: ALU_A_PC,   b: ALU_B_IMM};
            CLS_LUI:                        cfg = '{imm: IMM_U, a: ALU_A_ZERO, b: ALU_B_IMM};
            CLS_AUIPC:                      cfg = '{imm: IMM_U, a: ALU_A_PC,   b: ALU_B_IMM};
            CLS_JAL:                        cfg = '{imm: IMM_J, a: ALU_A_PC,   b: ALU_B_IMM};
            default:                        cfg = '{imm: IMM_I, a: ALU_A_RS1,  b: ALU_B_RS2};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_classify.sv
// rtl/multicycle_ctrl_classify.sv - combinational opcode classification and funct3 legality check
module ctrl_classify
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    output instr_class_t o_class,
    output logic         o_legal,
    output trap_cause_t  o_cause
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OPC_LOAD:   o_class = CLS_LOAD;
            OPC_STORE:  o_class = CLS_STORE;
            OPC_BRANCH: o_class = CLS_BRANCH;
            OPC_JAL:    o_class = CLS_JAL;
            OPC_JALR:   o_class = CLS_JALR;
            OPC_OP:     o_class = CLS_OP;
            OPC_OP_IMM: o_class = CLS_OP_IMM;
            OPC_LUI:    o_class = CLS_LUI;
            OPC_AUIPC:  o_class = CLS_AUIPC;
            OPC_FENCE:  o_class = CLS_FENCE;
            OPC_SYSTEM: o_class = CLS_SYSTEM;
            default:    o_class = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        o_legal = 1'b1;
        o_cause = TRAP_ILLEGAL_OPC;
        case (o_class)
            CLS_LOAD: begin
                o_legal = (i_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                o_cause = TRAP_ILLEGAL_F3;
            end
            CLS_STORE: begin
                o_legal = (i_funct3 <= 3'd2);
                o_cause = TRAP_ILLEGAL_F3;
            end
            CLS_BRANCH: begin
                o_legal = (i_funct3 != 3'd2) && (i_funct3 != 3'd3);
                o_cause = TRAP_ILLEGAL_F3;
            end
            CLS_JALR: begin
                o_legal = (i_funct3 == 3'd0);
                o_cause = TRAP_ILLEGAL_F3;
            end
            CLS_SYSTEM: begin
                o_legal = 1'b0;
                o_cause = TRAP_SYSTEM;
            end
            CLS_ILLEGAL: begin
                o_legal = 1'b0;
                o_cause = TRAP_ILLEGAL_OPC;
            end
            default: begin
                o_legal = 1'b1;
                o_cause = TRAP_ILLEGAL_OPC;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - fetch/decode/execute/memory/writeback sequencer for the multi-cycle RV32I core
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [1:0] RESET_PC_SEL = 2'd0,
    parameter int         INSTRET_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    input  logic                 imem_ack,
    output logic                 ir_we,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 branch_cond,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic [2:0]           imm_sel,
    output logic [1:0]           alu_a_sel,
    output logic [1:0]           alu_b_sel,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    ctrl_state_t          r_state;
    trap_cause_t          r_trap_cause;
    logic [INSTRET_W-1:0] r_instret;

    ctrl_state_t  w_next;
    instr_class_t w_class;
    logic         w_legal;
    trap_cause_t  w_cause;
    alu_cfg_t     w_cfg;
    logic         w_imem_req, w_ir_we, w_dmem_req, w_dmem_we;
    logic         w_pc_we, w_rf_we, w_retire, w_trap;
    imm_sel_t     w_imm_sel;
    alu_a_sel_t   w_alu_a_sel;
    alu_b_sel_t   w_alu_b_sel;
    pc_sel_t      w_pc_sel;
    wb_sel_t      w_wb_sel;

    ctrl_classify u_classify (
        .i_opcode (opcode),
        .i_funct3 (funct3),
        .o_class  (w_class),
        .o_legal  (w_legal),
        .o_cause  (w_cause)
    );

    assign w_cfg = alu_cfg(w_class);

    always_comb begin
        w_next      = r_state;
        w_imem_req  = 1'b0;
        w_ir_we     = 1'b0;
        w_dmem_req  = 1'b0;
        w_dmem_we   = 1'b0;
        w_imm_sel   = IMM_I;
        w_alu_a_sel = ALU_A_RS1;
        w_alu_b_sel = ALU_B_RS2;
        w_pc_we     = 1'b0;
        w_pc_sel    = PC_PC4;
        w_rf_we     = 1'b0;
        w_wb_sel    = WB_ALU;
        w_retire    = 1'b0;
        w_trap      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_ir_we = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: w_next = w_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                w_imm_sel   = w_cfg.imm;
                w_alu_a_sel = w_cfg.a;
                w_alu_b_sel = w_cfg.b;
                case (w_class)
                    CLS_BRANCH, CLS_FENCE: begin
                        w_pc_we  = 1'b1;
                        if ((w_class == CLS_BRANCH) && branch_cond) w_pc_sel = PC_TARGET;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: w_next = ST_MEM;
                    default:             w_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                w_imm_sel   = w_cfg.imm;
                w_alu_a_sel = w_cfg.a;
                w_alu_b_sel = w_cfg.b;
                w_dmem_req  = 1'b1;
                w_dmem_we   = (w_class == CLS_STORE);
                if (dmem_ack) begin
                    if (w_class == CLS_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // Selects stay on so JAL/JALR targets are still on the ALU output.
                w_imm_sel   = w_cfg.imm;
                w_alu_a_sel = w_cfg.a;
                w_alu_b_sel = w_cfg.b;
                w_rf_we     = 1'b1;
                w_pc_we     = 1'b1;
                w_retire    = 1'b1;
                w_next      = ST_FETCH;
                case (w_class)
                    CLS_LOAD:          w_wb_sel = WB_MEM;
                    CLS_JAL, CLS_JALR: w_wb_sel = WB_PC4;
                    default:           w_wb_sel = WB_ALU;
                endcase
                if ((w_class == CLS_JAL) || (w_class == CLS_JALR)) w_pc_sel = PC_TARGET;
            end
            ST_TRAP: w_trap = 1'b1;
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_trap_cause <= TRAP_ILLEGAL_OPC;
            r_instret    <= '0;
        end else begin
            r_state   <= w_next;
            r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, w_retire};
            if ((r_state == ST_DECODE) && !w_legal) r_trap_cause <= w_cause;
        end
    end

    assign imem_req   = rst_n & w_imem_req;
    assign ir_we      = rst_n & w_ir_we;
    assign dmem_req   = rst_n & w_dmem_req;
    assign dmem_we    = rst_n & w_dmem_we;
    assign imm_sel    = rst_n ? w_imm_sel   : 3'd0;
    assign alu_a_sel  = rst_n ? w_alu_a_sel : 2'd0;
    assign alu_b_sel  = rst_n ? w_alu_b_sel : 2'd0;
    assign pc_we      = rst_n & w_pc_we;
    assign pc_sel     = rst_n ? w_pc_sel    : RESET_PC_SEL;
    assign rf_we      = rst_n & w_rf_we;
    assign wb_sel     = rst_n ? w_wb_sel    : 2'd0;
    assign retire     = rst_n & w_retire;
    assign instret    = rst_n ? r_instret   : '0;
    assign trap       = rst_n & w_trap;
    assign trap_cause = rst_n ? r_trap_cause : 2'd0;

endmodule
